keccak_squeeze_unit: RTL

Parametrised squeeze/output stage that sits after the Keccak permutation core. It accepts rate blocks from the core over a valid/ready handshake and serialises them into W-bit words on a backpressured output stream. It masks the final partial word, supports SHAKE128/256 with arbitrary output length and SHA3-256/512 with fixed length, and requests further permutations until the requested byte count has been emitted.

---
 rtl/keccak_squeeze_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/keccak_squeeze_unit.sv
// Squeeze stage after the Keccak permutation: takes rate blocks from the core,
// serialises them into W-bit words, masks the tail word and requests more permutations.
module keccak_squeeze_unit #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344,
  parameter int LEN_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode_in,
  input  logic [LEN_W-1:0]    out_bytes_in,
  input  logic [RATE_MAX-1:0] block_in,
  input  logic                block_valid,
  output logic                block_ready,
  output logic                perm_req,
  input  logic                perm_ack,
  output logic [W-1:0]        data_out,
  output logic [W/8-1:0]      data_keep,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                data_last,
  output logic                busy,
  output logic                done
);

  localparam int NB     = W / 8;
  localparam int NB_LOG = (W == 64) ? 3 : 2;
  localparam int WC_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BLK,
    ST_DRAIN,
    ST_REQ
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [WC_W-1:0]     wc_q, wc_d;
  logic [RATE_MAX-1:0] buf_q, buf_d;
  logic                done_q, done_d;

  logic [LEN_W-1:0]    rem_words;
  logic [LEN_W-1:0]    word_bytes;
  logic [LEN_W-1:0]    rem_after;
  logic [WC_W-1:0]     wpb;
  logic [WC_W-1:0]     wc_load;
  logic [NB-1:0]       byte_keep;

  function automatic logic [WC_W-1:0] words_per_block(input logic [1:0] m);
    case (m)
      2'd0:    words_per_block = WC_W'(168 / NB);
      2'd3:    words_per_block = WC_W'(72 / NB);
      default: words_per_block = WC_W'(136 / NB);
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] job_len(input logic [1:0] m, input logic [LEN_W-1:0] req);
    case (m)
      2'd2:    job_len = LEN_W'(32);
      2'd3:    job_len = LEN_W'(64);
      default: job_len = req;
    endcase
  endfunction

  // ceil(rem/NB) without the overflow risk of adding NB-1 first
  assign rem_words  = (rem_q >> NB_LOG) + LEN_W'(|rem_q[NB_LOG-1:0]);
  assign wpb        = words_per_block(mode_q);
  assign wc_load    = (rem_words < LEN_W'(wpb)) ? rem_words[WC_W-1:0] : wpb;
  assign word_bytes = (rem_q < LEN_W'(NB)) ? rem_q : LEN_W'(NB);
  assign rem_after  = rem_q - word_bytes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'd0;
      rem_q   <= '0;
      wc_q    <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      wc_q    <= wc_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    wc_d    = wc_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode_in;
          rem_d  = job_len(mode_in, out_bytes_in);
          if (job_len(mode_in, out_bytes_in) == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_WAIT_BLK;
          end
        end
      end
      ST_WAIT_BLK: begin
        if (block_valid) begin
          buf_d   = block_in;
          wc_d    = wc_load;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (data_ready) begin
          buf_d = buf_q << W;
          wc_d  = wc_q - WC_W'(1);
          rem_d = rem_after;
          if (wc_q == WC_W'(1)) begin
            if (rem_after == '0) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        if (perm_ack) begin
          state_d = ST_WAIT_BLK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign block_ready = (state_q == ST_WAIT_BLK);
  assign perm_req    = (state_q == ST_REQ);
  assign data_valid  = (state_q == ST_DRAIN);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign data_last   = data_valid && (rem_q <= LEN_W'(NB));

  // byte gi counts from the MSB end of the word, i.e. stream order
  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    assign byte_keep[gi]              = data_valid && (rem_q > LEN_W'(gi));
    assign data_keep[NB-1-gi]         = byte_keep[gi];
    assign data_out[W-1-8*gi -: 8]    = byte_keep[gi] ? buf_q[RATE_MAX-1-8*gi -: 8] : 8'h00;
  end

endmodule
